sudoku_map_loader: RTL
======================

# sudoku_map_loader

Copies one stored puzzle from the constant map tables into the game board, one cell per clock. On `start` it picks a map index and difficulty and walks all 81 cells in row-major order. For each cell it emits a board write carrying the revealed digit (or 0 if hidden), a fixed/given flag and the solution digit. It sits directly downstream of `define_maps` and upstream of the board register file and game control FSM.

## Interface

Parameters
- `NUM_MAPS`, 8: maps per difficulty table; fixes the select width at 3 bits.
- `CELLS`, 81: cells per map.

Ports
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  load request, sampled only in IDLE
- `difficulty`  in  1  0 = easy tables, 1 = hard tables; latched on accepted start
- `map_sel`  in  3  explicit map index; present only with `MAP_LOADER_SEL_PORT_EN`
- `visibilities_easy`, `visibilities_hard`  in  1296 each  2 bits/cell × 81 × 8
- `maps_easy`, `maps_hard`  in  2592 each  4 bits/cell × 81 × 8
- `busy`  out  1  high while LOAD
- `done`  out  1  one-cycle pulse after the last write
- `map_id`  out  3  index of the map being or last loaded
- `wr_en`  out  1  board write strobe
- `wr_addr`  out  7  cell index 0..80, row-major (row×9+col)
- `wr_value`  out  4  visible digit 1..9, or 0 if hidden
- `wr_fixed`  out  1  1 = given cell (non-editable)
- `wr_solution`  out  4  solution digit 1..9
- `given_count`  out  7  number of visible cells; final at `done`

## Operation

- Table layout is MSB-first. Map k, cell c:
  - Solution digit is at `maps_x[2591-324k-4c -: 4]`.
  - Visibility pair is at `vis_x[1295-162k-2c -: 2]`; a cell is visible iff the pair is nonzero.
- `sel_ctr`: a 3-bit free-running counter, 0 on reset, incrementing every cycle and wrapping 7→0. It supplies pseudo-random map choice from user timing.
- States: IDLE, LOAD.
- IDLE with `start`=1:
  - Latch `difficulty`; `map_id` ← `sel_ctr` (or `map_sel` under macro).
  - Clear cell counter and `given_count`; go to LOAD.
- LOAD, every cycle:
  - `wr_en`=1, `wr_addr`=cell, `wr_solution`=digit.
  - `wr_fixed`=visible; `wr_value` = visible ? digit : 0.
  - `given_count` increments on each visible cell.
- LOAD after cell 80 is written: return to IDLE, pulse `done`, deassert `wr_en` and `busy`.
- `start` during LOAD is ignored; no queuing.
- Table inputs are treated as static constants and are not registered.
- Reset values: `busy`=0, `done`=0, `wr_en`=0, `wr_addr`=0, `wr_value`=0, `wr_fixed`=0, `wr_solution`=0, `map_id`=0, `given_count`=0, state IDLE.
- Reset mid-LOAD: return to IDLE at that edge; `wr_en`=0; no `done`. The board content is partial and owned by game control.

## Timing

- All outputs are registered.
- Edge E0 samples `start`=1 in IDLE:
  - After E0: `busy`=1, `wr_en`=1, `wr_addr`=0.
  - After En (1≤n≤80): `wr_addr`=n.
  - After E81: `wr_en`=0, `busy`=0, `done`=1, `given_count` final.
  - After E82: `done`=0.
- Latency from start edge to `done`: 81 cycles.
- Exactly 81 write strobes per load.
- Back-to-back loads: `start` high during the `done` cycle is accepted at E82, giving a new LOAD with no bubble beyond the `done` cycle.
- `wr_*` outputs hold their last values while `wr_en`=0; the board ignores them.
- `map_id` and `given_count` hold until the next accepted start.

## Configuration

- Macro: `MAP_LOADER_SEL_PORT_EN`.
- Defined: the `map_sel` input exists; `map_id` is latched from `map_sel` on accepted start. `sel_ctr` is still implemented but unused for selection. Used for deterministic debug and test.
- Undefined: no `map_sel` port; map chosen from `sel_ctr`.

## Test plan

- Reset, macro off, `start` high at the first edge after reset release, `difficulty`=0:
  - `map_id`=0; 81 writes with addresses 0..80.
  - Cell 0: `wr_value`=7, `wr_fixed`=1, `wr_solution`=7.
  - Cell 3: `wr_value`=0, `wr_fixed`=0, `wr_solution`=5.
  - `done` one cycle after address 80.
- Macro on, `map_sel`=0, `difficulty`=1:
  - Cell 0: `wr_value`=0, `wr_fixed`=0, `wr_solution`=1.
  - Cell 1: `wr_value`=6, `wr_fixed`=1.
- Macro on, sweep `map_sel` 0..7 for both difficulties:
  - Every write matches the golden model's table slice.
  - `given_count` equals the model's visible-cell count.
  - Each solution row contains 1..9 exactly once.
- `start` pulsed at cycle 20 of LOAD: ignored. Still exactly 81 writes and one `done`; `map_id` unchanged.
- `reset` asserted at cycle 40 of LOAD:
  - Next cycle all outputs are at reset values, with no `done`.
  - A fresh `start` then performs a full 81-write load.
- `start` held high continuously:
  - Loads run back-to-back with a period of 82 cycles.
  - `done` is high one cycle per load.
  - Macro off: `map_id` advances by 82 mod 8 = 2 per load.

Source files
------------

// File: rtl/sudoku_map_loader.sv
// sudoku_map_loader: copies one stored puzzle from the constant map tables
// into the game board, one cell per clock, in row-major order.
// Optional feature macro: MAP_LOADER_SEL_PORT_EN adds the map_sel input,
// which replaces the free-running sel_ctr as the source of the map index.
module sudoku_map_loader #(
    parameter int NUM_MAPS = 8,
    parameter int CELLS    = 81
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        difficulty,
`ifdef MAP_LOADER_SEL_PORT_EN
    input  logic [2:0]                  map_sel,
`endif
    input  logic [2*CELLS*NUM_MAPS-1:0] visibilities_easy,
    input  logic [2*CELLS*NUM_MAPS-1:0] visibilities_hard,
    input  logic [4*CELLS*NUM_MAPS-1:0] maps_easy,
    input  logic [4*CELLS*NUM_MAPS-1:0] maps_hard,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  map_id,
    output logic                        wr_en,
    output logic [6:0]                  wr_addr,
    output logic [3:0]                  wr_value,
    output logic                        wr_fixed,
    output logic [3:0]                  wr_solution,
    output logic [6:0]                  given_count
);
    localparam int VIS_W  = 2 * CELLS * NUM_MAPS;
    localparam int MAP_W  = 4 * CELLS * NUM_MAPS;
    localparam int VIDX_W = $clog2(VIS_W);
    localparam int MIDX_W = $clog2(MAP_W);
    localparam logic [6:0] LAST_CELL = 7'(CELLS - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sel_ctr_q, sel_ctr_d;
    logic              diff_q, diff_d;
    logic              done_q, done_d;
    logic [2:0]        map_id_q, map_id_d;
    logic [6:0]        wr_addr_q, wr_addr_d;
    logic [3:0]        wr_value_q, wr_value_d;
    logic              wr_fixed_q, wr_fixed_d;
    logic [3:0]        wr_solution_q, wr_solution_d;
    logic [6:0]        given_count_q, given_count_d;

    logic              accept;
    logic [2:0]        sel_src;
    logic [2:0]        look_k;
    logic [6:0]        look_c;
    logic              look_d;
    logic [MIDX_W-1:0] sol_idx;
    logic [VIDX_W-1:0] vis_idx;
    logic [3:0]        cell_sol;
    logic              cell_vis;

`ifdef MAP_LOADER_SEL_PORT_EN
    assign sel_src = map_sel;
`else
    assign sel_src = sel_ctr_q;
`endif

    // On the accepting edge the first cell is fetched with the incoming
    // selection; during LOAD the next cell of the latched map is fetched.
    assign accept = (state_q == IDLE) && start;
    assign look_k = accept ? sel_src : map_id_q;
    assign look_d = accept ? difficulty : diff_q;
    assign look_c = accept ? 7'd0 :
                    (wr_addr_q == LAST_CELL) ? wr_addr_q : wr_addr_q + 7'd1;

    // Table lookup: MSB-first slices of the selected map and cell
    always_comb begin
        sol_idx  = MIDX_W'(MAP_W - 1 - 4 * CELLS * int'(look_k) - 4 * int'(look_c));
        vis_idx  = VIDX_W'(VIS_W - 1 - 2 * CELLS * int'(look_k) - 2 * int'(look_c));
        cell_sol = look_d ? maps_hard[sol_idx -: 4] : maps_easy[sol_idx -: 4];
        cell_vis = look_d ? |visibilities_hard[vis_idx -: 2]
                          : |visibilities_easy[vis_idx -: 2];
    end

    // Next-state and registered-output logic for the IDLE/LOAD walk
    always_comb begin
        state_d       = state_q;
        sel_ctr_d     = sel_ctr_q + 3'd1;
        diff_d        = diff_q;
        done_d        = 1'b0;
        map_id_d      = map_id_q;
        wr_addr_d     = wr_addr_q;
        wr_value_d    = wr_value_q;
        wr_fixed_d    = wr_fixed_q;
        wr_solution_d = wr_solution_q;
        given_count_d = given_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = LOAD;
                    diff_d        = difficulty;
                    map_id_d      = sel_src;
                    wr_addr_d     = 7'd0;
                    wr_solution_d = cell_sol;
                    wr_fixed_d    = cell_vis;
                    wr_value_d    = cell_vis ? cell_sol : 4'd0;
                    given_count_d = {6'd0, cell_vis};
                end
            end
            LOAD: begin
                if (wr_addr_q == LAST_CELL) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    wr_addr_d     = wr_addr_q + 7'd1;
                    wr_solution_d = cell_sol;
                    wr_fixed_d    = cell_vis;
                    wr_value_d    = cell_vis ? cell_sol : 4'd0;
                    given_count_d = given_count_q + {6'd0, cell_vis};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_ctr_q     <= 3'd0;
            diff_q        <= 1'b0;
            done_q        <= 1'b0;
            map_id_q      <= 3'd0;
            wr_addr_q     <= 7'd0;
            wr_value_q    <= 4'd0;
            wr_fixed_q    <= 1'b0;
            wr_solution_q <= 4'd0;
            given_count_q <= 7'd0;
        end else begin
            state_q       <= state_d;
            sel_ctr_q     <= sel_ctr_d;
            diff_q        <= diff_d;
            done_q        <= done_d;
            map_id_q      <= map_id_d;
            wr_addr_q     <= wr_addr_d;
            wr_value_q    <= wr_value_d;
            wr_fixed_q    <= wr_fixed_d;
            wr_solution_q <= wr_solution_d;
            given_count_q <= given_count_d;
        end
    end

    assign busy        = (state_q == LOAD);
    assign wr_en       = (state_q == LOAD);
    assign done        = done_q;
    assign map_id      = map_id_q;
    assign wr_addr     = wr_addr_q;
    assign wr_value    = wr_value_q;
    assign wr_fixed    = wr_fixed_q;
    assign wr_solution = wr_solution_q;
    assign given_count = given_count_q;

endmodule
